// File: rtl/aes_encipher_seq_if.sv
// Bus between the AES encipher datapath, its controller and the round-key memory.
interface aes_encipher_seq_if;
  logic         next;
  logic         keylen;
  logic         key_ready;
  logic [127:0] block;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [127:0] new_block;
  logic         ready;

  modport slave (
    input  next, keylen, key_ready, block, round_key,
    output round, new_block, ready
  );

  modport master (
    output next, keylen, key_ready, block, round_key,
    input  round, new_block, ready
  );
endinterface

// File: rtl/aes_encipher_seq.sv
// Iterative AES-128/256 encipher datapath: one round per clock, round key fetched by index.
// Optional macro AES_ENC_ABORT_EN adds an abort input that cancels an operation in flight.
module aes_encipher_seq #(
  parameter int NUM_ROUNDS_128 = 10,
  parameter int NUM_ROUNDS_256 = 14
) (
  input logic clk,
  input logic reset,
`ifdef AES_ENC_ABORT_EN
  input logic abort,
`endif
  aes_encipher_seq_if.slave bus
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_MAIN, S_FINAL} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] new_block_q, new_block_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [3:0]   last_main;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 4*c+r is row r of column c; column 0 sits in the top 32 bits.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 8 * (4 * c + w) -: 8] = sbox(s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      r[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    new_block_d = new_block_q;
    round_ctr_d = round_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    last_main   = keylen_q ? 4'(NUM_ROUNDS_256 - 1) : 4'(NUM_ROUNDS_128 - 1);
    case (fsm_q)
      S_IDLE: begin
        if (bus.next && bus.key_ready) begin
          state_d     = bus.block ^ bus.round_key;
          keylen_d    = bus.keylen;
          round_ctr_d = 4'd1;
          ready_d     = 1'b0;
          fsm_d       = S_MAIN;
        end
      end
      S_MAIN: begin
        state_d     = mix_columns(sub_shift(state_q)) ^ bus.round_key;
        round_ctr_d = round_ctr_q + 4'd1;
        if (round_ctr_q == last_main) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        new_block_d = sub_shift(state_q) ^ bus.round_key;
        ready_d     = 1'b1;
        round_ctr_d = 4'd0;
        fsm_d       = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
`ifdef AES_ENC_ABORT_EN
    // Abort drops the operation without touching the previous ciphertext.
    if (abort && fsm_q != S_IDLE) begin
      fsm_d       = S_IDLE;
      state_d     = state_q;
      new_block_d = new_block_q;
      round_ctr_d = 4'd0;
      ready_d     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      new_block_q <= '0;
      round_ctr_q <= 4'd0;
      keylen_q    <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      new_block_q <= new_block_d;
      round_ctr_q <= round_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.round     = round_ctr_q;
  assign bus.new_block = new_block_q;
  assign bus.ready     = ready_q;
endmodule

// File: tb/tb_aes_encipher_seq.sv
// Bench for aes_encipher_seq: behavioural key memory, FIPS-197 vectors, ciphertext/latency scoreboard.
module tb_aes_encipher_seq;
  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] ct;
    int           lat;
    int           st;
  } sb_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         abort = 1'b0;
  logic         rdy_prev = 1'b1;
  logic [127:0] rk [0:15];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  sb_t          sb_q[$];

  aes_encipher_seq_if bus();

  aes_encipher_seq dut (
    .clk   (clk),
    .reset (reset),
`ifdef AES_ENC_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.round_key = rk[bus.round];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SB[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // FIPS-197 key expansion feeding the behavioural key memory.
  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk, nw;
    nk = kl ? 8 : 4;
    nw = kl ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < nw / 4; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Output monitor: every ready rise outside reset/abort pops one expected result.
  always @(posedge clk) begin
    sb_t e;
    cyc = cyc + 1;
    #1;
    if (!reset && !abort && bus.ready && !rdy_prev) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 128'(sb_q.size()), 128'd1);
      end else begin
        e = sb_q.pop_front();
        chk("ciphertext", bus.new_block, e.ct);
        chk("latency", 128'(cyc - e.st), 128'(e.lat));
      end
    end
    rdy_prev = bus.ready;
  end

  // Called at a falling edge; returns at the falling edge where ready is first seen high.
  task automatic enc(input logic [255:0] key, input logic kl, input logic [127:0] ct, input bit disturb);
    int  nr;
    sb_t e;
    nr = kl ? 14 : 10;
    load_key(key, kl);
    bus.block     = PT;
    bus.keylen    = kl;
    bus.key_ready = 1'b1;
    bus.next      = 1'b1;
    e.ct  = ct;
    e.lat = nr + 1;
    e.st  = cyc;
    sb_q.push_back(e);
    for (int k = 1; k <= nr + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.next = 1'b0;
        chk("busy", 128'(bus.ready), 128'd0);
      end
      if (disturb && k == 2) bus.next = 1'b1;
      if (disturb && k == 3) begin
        bus.next   = 1'b0;
        bus.block  = '0;
        bus.keylen = ~kl;
      end
      if (k <= nr) chk("round", 128'(bus.round), 128'(k));
    end
    chk("ready_done", 128'(bus.ready), 128'd1);
    chk("round_idle", 128'(bus.round), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 16; r++) rk[r] = '0;
    bus.next      = 1'b0;
    bus.keylen    = 1'b0;
    bus.key_ready = 1'b1;
    bus.block     = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(bus.ready), 128'd1);
    chk("rst_new_block", bus.new_block, 128'd0);
    chk("rst_round", 128'(bus.round), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    enc(K128, 1'b0, CT128, 1'b0);
    enc(K256, 1'b1, CT256, 1'b0);

    // Start request while the key memory is not ready must be dropped.
    bus.key_ready = 1'b0;
    bus.next      = 1'b1;
    repeat (2) @(negedge clk);
    chk("nokey_ready", 128'(bus.ready), 128'd1);
    chk("nokey_round", 128'(bus.round), 128'd0);
    chk("nokey_hold", bus.new_block, CT256);
    bus.next      = 1'b0;
    bus.key_ready = 1'b1;

    enc(K128, 1'b0, CT128, 1'b1);

    // Reset in the middle of an AES-128 run.
    load_key(K128, 1'b0);
    bus.block = PT;
    bus.keylen = 1'b0;
    bus.next  = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    for (int i = 0; i < 20 && bus.round != 4'd5; i++) @(negedge clk);
    chk("reached_round5", 128'(bus.round), 128'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 128'(bus.ready), 128'd1);
    chk("midrst_round", 128'(bus.round), 128'd0);
    chk("midrst_new_block", bus.new_block, 128'd0);
    reset = 1'b0;

    enc(K128, 1'b0, CT128, 1'b0);
    enc(K256, 1'b1, CT256, 1'b0);
    enc(K128, 1'b0, CT128, 1'b0);

`ifdef AES_ENC_ABORT_EN
    load_key(K256, 1'b1);
    bus.block  = PT;
    bus.keylen = 1'b1;
    bus.next   = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    for (int i = 0; i < 20 && bus.round != 4'd3; i++) @(negedge clk);
    chk("reached_round3", 128'(bus.round), 128'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", 128'(bus.ready), 128'd1);
    chk("abort_round", 128'(bus.round), 128'd0);
    chk("abort_hold", bus.new_block, CT128);
    enc(K256, 1'b1, CT256, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
